// File: rtl/main.sv
// ---------------------------------------------------------------------------
// main: registered four-digit packed-BCD divisibility checker.
//
// The 4-digit number N = D C B A is sampled on every rising clock edge.
// `result` goes high one cycle later when N is divisible by 3 or by 11 and
// every digit is a legal BCD digit (0..9). An illegal digit forces result 0.
//
// Optional feature macro: MAIN_BCD_ERR_EN
//   When defined, the registered `bcd_err` output is added. It is 1 when any
//   digit is greater than 9.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears all outputs
//   a3..a0   in   units digit (a3 = MSB)
//   b3..b0   in   tens digit
//   c3..c0   in   hundreds digit
//   d3..d0   in   thousands digit
//   result   out  registered: N divisible by 3 or 11, all digits valid
//   bcd_err  out  registered: some digit > 9 (MAIN_BCD_ERR_EN only)
// ---------------------------------------------------------------------------
module main (
    input  logic clk,
    input  logic rst_n,
    input  logic a3,
    input  logic a2,
    input  logic a1,
    input  logic a0,
    input  logic b3,
    input  logic b2,
    input  logic b1,
    input  logic b0,
    input  logic c3,
    input  logic c2,
    input  logic c1,
    input  logic c0,
    input  logic d3,
    input  logic d2,
    input  logic d1,
    input  logic d0,
`ifdef MAIN_BCD_ERR_EN
    output logic bcd_err,
`endif
    output logic result
);

    // Digit-sum reduction mod 3. Because 4 and 16 are both 1 (mod 3), adding
    // the three 2-bit chunks of the 6-bit sum keeps the residue. The reduced
    // value is at most 9, so a four-way compare finishes the test.
    function automatic logic is_div3(input logic [5:0] s3);
        logic [3:0] red;
        red = {2'b00, s3[5:4]} + {2'b00, s3[3:2]} + {2'b00, s3[1:0]};
        return (red == 4'd0) || (red == 4'd3) || (red == 4'd6) || (red == 4'd9);
    endfunction

    // Alternating digit sum. It ranges over -18..18, so only -11, 0 and +11
    // are multiples of 11.
    function automatic logic is_div11(input logic [4:0] e, input logic [4:0] o);
        logic signed [5:0] diff;
        diff = $signed({1'b0, e}) - $signed({1'b0, o});
        return (diff == 6'sd0) || (diff == 6'sd11) || (diff == -6'sd11);
    endfunction

    logic [3:0] dig_a, dig_b, dig_c, dig_d;
    logic [5:0] sum3;
    logic [4:0] even_sum, odd_sum;
    logic       valid;
    logic       bad_digit;
    logic       next_result;

    assign dig_a = {a3, a2, a1, a0};
    assign dig_b = {b3, b2, b1, b0};
    assign dig_c = {c3, c2, c1, c0};
    assign dig_d = {d3, d2, d1, d0};

    assign sum3     = {2'b00, dig_a} + {2'b00, dig_b} + {2'b00, dig_c} + {2'b00, dig_d};
    assign even_sum = {1'b0, dig_a} + {1'b0, dig_c};
    assign odd_sum  = {1'b0, dig_b} + {1'b0, dig_d};

    assign bad_digit   = (dig_a > 4'd9) || (dig_b > 4'd9) || (dig_c > 4'd9) || (dig_d > 4'd9);
    assign valid       = ~bad_digit;
    assign next_result = valid & (is_div3(sum3) | is_div11(even_sum, odd_sum));

    // Output register stage
    logic result_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1 <= 1'b0;
        end else begin
            result_p1 <= next_result;
        end
    end

    assign result = result_p1;

`ifdef MAIN_BCD_ERR_EN
    logic bcd_err_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_err_p1 <= 1'b0;
        end else begin
            bcd_err_p1 <= bad_digit;
        end
    end

    assign bcd_err = bcd_err_p1;
`endif

endmodule

// File: tb/tb_main.sv
// ---------------------------------------------------------------------------
// tb_main: directed self-checking bench for main.
// Build with +define+MAIN_BCD_ERR_EN to also check the bcd_err output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_main;

    logic       clk;
    logic       rst_n;
    logic [3:0] a, b, c, d;
    logic       result;
`ifdef MAIN_BCD_ERR_EN
    logic       bcd_err;
`endif

    int tests;
    int fails;

    main dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a3     (a[3]), .a2(a[2]), .a1(a[1]), .a0(a[0]),
        .b3     (b[3]), .b2(b[2]), .b1(b[1]), .b0(b[0]),
        .c3     (c[3]), .c2(c[2]), .c1(c[1]), .c0(c[0]),
        .d3     (d[3]), .d2(d[2]), .d1(d[1]), .d0(d[0]),
`ifdef MAIN_BCD_ERR_EN
        .bcd_err(bcd_err),
`endif
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_res(input string tag, input logic exp);
        tests++;
        assert (result === exp) else begin
            fails++;
            $error("FAIL %s: result=%b expected=%b", tag, result, exp);
        end
    endtask

    task automatic check_err(input string tag, input logic exp);
`ifdef MAIN_BCD_ERR_EN
        tests++;
        assert (bcd_err === exp) else begin
            fails++;
            $error("FAIL %s: bcd_err=%b expected=%b", tag, bcd_err, exp);
        end
`else
        if (exp) begin
        end
        if (tag.len() == 0) begin
        end
`endif
    endtask

    // Drive digits D C B A, take one rising edge, sample 1 ns after it.
    task automatic apply(input logic [3:0] dd, input logic [3:0] cc,
                         input logic [3:0] bb, input logic [3:0] aa,
                         input logic exp, input logic exp_err, input string tag);
        d = dd; c = cc; b = bb; a = aa;
        @(posedge clk);
        #1;
        check_res(tag, exp);
        check_err(tag, exp_err);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        d = 4'd9; c = 4'd9; b = 4'd9; a = 4'd9;

        // Reset held with inputs that would otherwise give 1
        repeat (2) @(posedge clk);
        #1;
        check_res("reset_hold", 1'b0);
        check_err("reset_hold_err", 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        apply(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "zero");
        apply(4'd4, 4'd3, 4'd5, 4'd3, 1'b1, 1'b0, "4353_div3");
        apply(4'd3, 4'd5, 4'd7, 4'd8, 1'b0, 1'b0, "3578_none");
        apply(4'd3, 4'd5, 4'd4, 4'd2, 1'b1, 1'b0, "3542_div11");
        apply(4'd0, 4'd3, 4'd6, 4'd3, 1'b1, 1'b0, "0363");
        apply(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 1'b0, "9999");
        apply(4'd0, 4'd2, 4'd0, 4'd9, 1'b1, 1'b0, "0209_diff_p11");
        apply(4'd9, 4'd0, 4'd2, 4'd0, 1'b1, 1'b0, "9020_diff_m11");
        apply(4'd1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "1000");
        apply(4'd0, 4'd0, 4'd1, 4'd1, 1'b1, 1'b0, "0011");
        apply(4'd0, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, "0010");
        apply(4'd0, 4'd0, 4'd0, 4'd12, 1'b0, 1'b1, "a_invalid");
        // 15 in the thousands: digit sum 15 would be div by 3 if accepted
        apply(4'd15, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, "d_invalid");
        apply(4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, "recover_3");

        // Mid-cycle input change must not reach result before the next edge
        apply(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, "pre_mid");
        #2;
        d = 4'd1; c = 4'd0; b = 4'd0; a = 4'd0;
        #1;
        check_res("mid_cycle_hold", 1'b1);
        @(posedge clk);
        #1;
        check_res("mid_cycle_next_edge", 1'b0);

        // Asynchronous reset between edges
        apply(4'd0, 4'd0, 4'd0, 4'd6, 1'b1, 1'b0, "pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check_res("async_clear", 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_res("post_reset_first_edge", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
